rf_cmd_ctrl: RTL and testbench

RF_CMD_CTRL -- requirements
Module: rf_cmd_ctrl

---
 rtl/rf_cmd_ctrl_if.sv | 29 ++
 rtl/rf_cmd_ctrl.sv | 154 +++++++++++++++
 tb/tb_rf_cmd_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_cmd_ctrl_if.sv
// Byte-command, register-file and transmit signals of rf_cmd_ctrl.
// master = the command controller, slave = the surrounding receiver/RF/transmitter.
interface rf_cmd_ctrl_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4
);
  logic [DATA_WIDTH-1:0]    RX_DATA;
  logic                     RX_VALID;
  logic [DATA_WIDTH-1:0]    RF_RD_DATA;
  logic                     RF_RD_VALID;
  logic                     TX_BUSY;
  logic                     RF_WR_EN;
  logic                     RF_RD_EN;
  logic [ADDRESS_WIDTH-1:0] RF_ADDR;
  logic [DATA_WIDTH-1:0]    RF_WR_DATA;
  logic [DATA_WIDTH-1:0]    TX_DATA;
  logic                     TX_VALID;
  logic                     CMD_ERR;

  modport master (
    input  RX_DATA, RX_VALID, RF_RD_DATA, RF_RD_VALID, TX_BUSY,
    output RF_WR_EN, RF_RD_EN, RF_ADDR, RF_WR_DATA, TX_DATA, TX_VALID, CMD_ERR
  );

  modport slave (
    output RX_DATA, RX_VALID, RF_RD_DATA, RF_RD_VALID, TX_BUSY,
    input  RF_WR_EN, RF_RD_EN, RF_ADDR, RF_WR_DATA, TX_DATA, TX_VALID, CMD_ERR
  );
endinterface

// File: rtl/rf_cmd_ctrl.sv
// Byte-command decoder driving a register file: 0xAA addr data writes, 0xBB addr reads
// and returns the read byte to the transmitter. All outputs are registered.
module rf_cmd_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4,
  parameter int TIMEOUT       = 255
) (
  input logic            CLK,
  input logic            RST,
  rf_cmd_ctrl_if.master  bus
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]      IDLE_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [2:0]            RD_LAST   = 3'd4;
  localparam logic [DATA_WIDTH-1:0] CMD_WR    = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD    = DATA_WIDTH'(8'hBB);

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND} state_t;

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         idle_cnt, idle_nxt;
  logic [2:0]               rd_cnt, rd_cnt_nxt;
  logic                     wr_en_q, wr_en_nxt;
  logic                     rd_en_q, rd_en_nxt;
  logic                     tx_vld_q, tx_vld_nxt;
  logic                     err_q, err_nxt;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_nxt;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_nxt;
  logic [DATA_WIDTH-1:0]    txd_q, txd_nxt;
  logic                     addr_ok;
  logic                     idle_expired;

  // An address byte is legal only if nothing is set above the register-file address range.
  assign addr_ok      = ((bus.RX_DATA >> ADDRESS_WIDTH) == '0);
  assign idle_expired = !bus.RX_VALID && (idle_cnt == IDLE_LAST);

  always_comb begin
    state_nxt  = state;
    idle_nxt   = '0;
    rd_cnt_nxt = '0;
    wr_en_nxt  = 1'b0;
    rd_en_nxt  = 1'b0;
    tx_vld_nxt = 1'b0;
    err_nxt    = 1'b0;
    addr_nxt   = addr_q;
    wdata_nxt  = wdata_q;
    txd_nxt    = txd_q;

    case (state)
      IDLE: begin
        if (bus.RX_VALID) begin
          if (bus.RX_DATA == CMD_WR)      state_nxt = WR_ADDR;
          else if (bus.RX_DATA == CMD_RD) state_nxt = RD_ADDR;
          else                            err_nxt   = 1'b1;
        end
      end

      WR_ADDR, RD_ADDR: begin
        if (bus.RX_VALID) begin
          if (addr_ok) begin
            addr_nxt = bus.RX_DATA[ADDRESS_WIDTH-1:0];
            if (state == WR_ADDR) begin
              state_nxt = WR_DATA;
            end else begin
              rd_en_nxt = 1'b1;
              state_nxt = RD_WAIT;
            end
          end else begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end
        end else if (idle_expired) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          idle_nxt = idle_cnt + 1'b1;
        end
      end

      WR_DATA: begin
        if (bus.RX_VALID) begin
          wr_en_nxt = 1'b1;
          wdata_nxt = bus.RX_DATA;
          state_nxt = IDLE;
        end else if (idle_expired) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          idle_nxt = idle_cnt + 1'b1;
        end
      end

      // Bytes arriving while a read is in flight are dropped and flagged; the read carries on.
      RD_WAIT: begin
        err_nxt = bus.RX_VALID;
        if (bus.RF_RD_VALID) begin
          txd_nxt   = bus.RF_RD_DATA;
          state_nxt = TX_SEND;
        end else if (rd_cnt == RD_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          rd_cnt_nxt = rd_cnt + 1'b1;
        end
      end

      TX_SEND: begin
        err_nxt = bus.RX_VALID;
        if (!bus.TX_BUSY) begin
          tx_vld_nxt = 1'b1;
          state_nxt  = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      idle_cnt <= '0;
      rd_cnt   <= '0;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      tx_vld_q <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      txd_q    <= '0;
    end else begin
      state    <= state_nxt;
      idle_cnt <= idle_nxt;
      rd_cnt   <= rd_cnt_nxt;
      wr_en_q  <= wr_en_nxt;
      rd_en_q  <= rd_en_nxt;
      tx_vld_q <= tx_vld_nxt;
      err_q    <= err_nxt;
      addr_q   <= addr_nxt;
      wdata_q  <= wdata_nxt;
      txd_q    <= txd_nxt;
    end
  end

  assign bus.RF_WR_EN   = wr_en_q;
  assign bus.RF_RD_EN   = rd_en_q;
  assign bus.RF_ADDR    = addr_q;
  assign bus.RF_WR_DATA = wdata_q;
  assign bus.TX_DATA    = txd_q;
  assign bus.TX_VALID   = tx_vld_q;
  assign bus.CMD_ERR    = err_q;

endmodule

// File: tb/tb_rf_cmd_ctrl.sv
// Randomised command traffic for rf_cmd_ctrl; each transaction books the strobes it must
// cause into a per-cycle expectation table that a negedge monitor compares against.
module tb_rf_cmd_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int TO = 255;
  localparam int N  = 20000;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  rf_cmd_ctrl_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  rf_cmd_ctrl #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .TIMEOUT(TO)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int now    = 0;
  bit mon_on = 1'b0;

  // Expected events per cycle index
  bit          e_wr  [N];
  bit          e_rd  [N];
  bit          e_tx  [N];
  bit          e_err [N];
  bit          e_lat [N];
  logic [7:0]  e_wd  [N];
  logic [7:0]  e_lv  [N];
  logic [3:0]  e_addr[N];
  logic [7:0]  exp_txd = 8'h00;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h at cycle %0d", tag, obs, exp, now);
    end
  endtask

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  function automatic logic [7:0] rbyte();
    return 8'($urandom);
  endfunction

  function automatic int gap();
    return ($urandom_range(0, 7) == 0) ? TO - 1 : int'($urandom_range(0, 2));
  endfunction

  // Inputs change 1 time unit after the rising edge; they are sampled at the next one.
  task automatic step(bit rxv, logic [7:0] rxd, bit rdv, logic [7:0] rdd, bit busy);
    @(posedge CLK);
    #1;
    now++;
    bus.RX_VALID    = rxv;
    bus.RX_DATA     = rxd;
    bus.RF_RD_VALID = rdv;
    bus.RF_RD_DATA  = rdd;
    bus.TX_BUSY     = busy;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, rbyte(), rb(), rbyte(), rb());
  endtask

  task automatic send(logic [7:0] b);
    step(1'b1, b, rb(), rbyte(), rb());
  endtask

  task automatic do_write(logic [3:0] a, logic [7:0] d, int g1, int g2);
    send(8'hAA);
    idle(g1);
    send({4'h0, a});
    idle(g2);
    send(d);
    e_wr[now+1]   = 1'b1;
    e_addr[now+1] = a;
    e_wd[now+1]   = d;
  endtask

  task automatic do_read(logic [3:0] a, logic [7:0] d, int lat, int busy_n,
                         bit stray_wait, bit stray_tx);
    int r;
    send(8'hBB);
    idle(gap());
    send({4'h0, a});
    r = now + 1;
    e_rd[r]   = 1'b1;
    e_addr[r] = a;
    for (int i = 0; i < lat; i++) begin
      step(stray_wait && i == 0, rbyte(), 1'b0, rbyte(), rb());
      if (stray_wait && i == 0) e_err[now+1] = 1'b1;
    end
    step(1'b0, rbyte(), 1'b1, d, rb());
    e_lat[now+1] = 1'b1;
    e_lv[now+1]  = d;
    for (int i = 0; i < busy_n; i++) begin
      step(stray_tx && i == 0, rbyte(), rb(), rbyte(), 1'b1);
      if (stray_tx && i == 0) e_err[now+1] = 1'b1;
    end
    step(1'b0, rbyte(), rb(), rbyte(), 1'b0);
    e_tx[now+1] = 1'b1;
  endtask

  task automatic do_read_timeout(logic [3:0] a);
    send(8'hBB);
    send({4'h0, a});
    e_rd[now+1]   = 1'b1;
    e_addr[now+1] = a;
    for (int i = 0; i < 5; i++) step(1'b0, rbyte(), 1'b0, rbyte(), rb());
    e_err[now+1] = 1'b1;
  endtask

  task automatic do_bad_cmd(logic [7:0] b);
    send(b);
    e_err[now+1] = 1'b1;
  endtask

  task automatic do_bad_addr(bit rd, logic [7:0] ab);
    send(rd ? 8'hBB : 8'hAA);
    idle(gap());
    send(ab);
    e_err[now+1] = 1'b1;
  endtask

  // kind 0: stall after 0xAA, 1: after a write address, 2: after 0xBB
  task automatic do_stall(int kind, logic [3:0] a);
    send(kind == 2 ? 8'hBB : 8'hAA);
    if (kind == 1) send({4'h0, a});
    idle(TO);
    e_err[now+1] = 1'b1;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_wr_en"},   32'(bus.RF_WR_EN),   32'd0);
    chk({tag, "_rd_en"},   32'(bus.RF_RD_EN),   32'd0);
    chk({tag, "_tx_vld"},  32'(bus.TX_VALID),   32'd0);
    chk({tag, "_cmd_err"}, 32'(bus.CMD_ERR),    32'd0);
    chk({tag, "_addr"},    32'(bus.RF_ADDR),    32'd0);
    chk({tag, "_wdata"},   32'(bus.RF_WR_DATA), 32'd0);
    chk({tag, "_txd"},     32'(bus.TX_DATA),    32'd0);
  endtask

  always @(negedge CLK) begin
    if (mon_on && now < N) begin
      if (e_lat[now]) exp_txd = e_lv[now];
      chk("wr_en",    32'(bus.RF_WR_EN), 32'(e_wr[now]));
      chk("rd_en",    32'(bus.RF_RD_EN), 32'(e_rd[now]));
      chk("tx_valid", 32'(bus.TX_VALID), 32'(e_tx[now]));
      chk("cmd_err",  32'(bus.CMD_ERR),  32'(e_err[now]));
      chk("tx_data",  32'(bus.TX_DATA),  32'(exp_txd));
      if (e_wr[now]) begin
        chk("wr_addr", 32'(bus.RF_ADDR),    32'(e_addr[now]));
        chk("wr_data", 32'(bus.RF_WR_DATA), 32'(e_wd[now]));
      end
      if (e_rd[now]) chk("rd_addr", 32'(bus.RF_ADDR), 32'(e_addr[now]));
    end
  end

  initial begin
    bus.RX_VALID    = 1'b0;
    bus.RX_DATA     = '0;
    bus.RF_RD_VALID = 1'b0;
    bus.RF_RD_DATA  = '0;
    bus.TX_BUSY     = 1'b0;

    repeat (3) step(1'b0, rbyte(), rb(), rbyte(), rb());
    chk_all_zero("reset");
    RST    = 1'b1;
    mon_on = 1'b1;
    idle(2);

    // Directed cases
    do_write(4'h3, 8'h5C, 0, 0);
    do_read(4'h2, 8'h81, 1, 0, 1'b0, 1'b0);
    do_read(4'h7, 8'h3E, 2, 10, 1'b0, 1'b0);
    do_bad_cmd(8'h12);
    do_bad_addr(1'b0, 8'h1F);
    do_bad_addr(1'b1, 8'h80);
    do_stall(1, 4'h1);
    do_write(4'hF, 8'hA5, TO - 1, TO - 1);
    do_read_timeout(4'h9);
    do_read(4'h0, 8'hFF, 4, 1, 1'b1, 1'b1);
    do_write(4'h1, 8'h11, 0, 0);
    do_write(4'h2, 8'h22, 0, 0);
    do_read(4'h5, 8'h5A, 0, 0, 1'b0, 1'b0);

    // Reset while a read waits for RF data: nothing may come out afterwards
    begin
      send(8'hBB);
      send(8'h04);
      e_rd[now+1]   = 1'b1;
      e_addr[now+1] = 4'h4;
      step(1'b0, rbyte(), 1'b0, rbyte(), 1'b0);
      step(1'b0, rbyte(), 1'b0, rbyte(), 1'b0);
      RST = 1'b0;
      e_lat[now] = 1'b1;
      e_lv[now]  = 8'h00;
      #1;
      chk_all_zero("midrst");
      step(1'b0, rbyte(), 1'b1, 8'hC3, 1'b0);
      step(1'b0, rbyte(), 1'b1, 8'hC3, 1'b0);
      RST = 1'b1;
      step(1'b0, rbyte(), 1'b1, 8'h3C, 1'b0);
      idle(10);
    end

    // Randomised mix
    for (int t = 0; t < 80 && now < N - 1000; t++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: do_write(4'($urandom), rbyte(), gap(), gap());
        3, 4, 5: do_read(4'($urandom), rbyte(), int'($urandom_range(0, 4)),
                         ($urandom_range(0, 5) == 0) ? 10 : int'($urandom_range(0, 3)),
                         $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        6:       do_read_timeout(4'($urandom));
        7: begin
          logic [7:0] b;
          b = rbyte();
          if (b == 8'hAA || b == 8'hBB) b = 8'h00;
          do_bad_cmd(b);
        end
        8:       do_bad_addr(rb(), {4'($urandom_range(1, 15)), 4'($urandom)});
        default: do_stall(int'($urandom_range(0, 2)), 4'($urandom));
      endcase
      idle(int'($urandom_range(0, 2)));
    end

    idle(12);
    mon_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
